// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported 32-bit RAM between instruction fetch and the load/store unit.
// One access in flight; data has priority with a bounded starvation window for fetch.
module unified_mem_arbiter #(
   parameter int MEM_LAT      = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [1:0]  d_size,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        d_err,
   output logic        m_en,
   output logic        m_we,
   output logic [3:0]  m_be,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   input  logic [31:0] m_rdata,
   output logic        busy
);

   localparam int CNT_W = $clog2(MEM_LAT + 1);
   localparam int STV_W = $clog2(STARVE_LIMIT + 1);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [STV_W-1:0]  starve;
   logic              own_d, own_we, own_err;
   logic              if_rvalid_q, d_rvalid_q, d_err_q;
   logic [31:0]       if_rdata_q, d_rdata_q;
   logic              d_bad, fetch_wins, last_cycle;
   logic [3:0]        d_be;
   logic [31:0]       d_wrep;

   assign d_bad = (d_size == 2'b11)
                | ((d_size == 2'b01) && d_addr[0])
                | ((d_size == 2'b10) && (d_addr[1:0] != 2'b00));

   assign fetch_wins = if_req && (!d_req || (starve == STV_W'(STARVE_LIMIT)));
   assign last_cycle = (state == WAIT) && (cnt == CNT_W'(1));

   always_comb begin
      d_be   = 4'h0;
      d_wrep = 32'h0;
      case (d_size)
         2'b00: begin
            d_be   = 4'b0001 << d_addr[1:0];
            d_wrep = {4{d_wdata[7:0]}};
         end
         2'b01: begin
            d_be   = 4'b0011 << {d_addr[1], 1'b0};
            d_wrep = {2{d_wdata[15:0]}};
         end
         2'b10: begin
            d_be   = 4'hF;
            d_wrep = d_wdata;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      if_gnt    = 1'b0;
      d_gnt     = 1'b0;
      m_en      = 1'b0;
      m_we      = 1'b0;
      m_be      = 4'h0;
      m_addr    = 32'h0;
      m_wdata   = 32'h0;
      case (state)
         IDLE: begin
            if (!rst && (if_req || d_req)) begin
               state_nxt = WAIT;
               if (fetch_wins) begin
                  if_gnt = 1'b1;
                  m_en   = 1'b1;
                  m_be   = 4'hF;
                  m_addr = {if_addr[31:2], 2'b00};
               end else begin
                  // A bad access still burns the slot but never touches the RAM.
                  d_gnt   = 1'b1;
                  m_en    = !d_bad;
                  m_we    = d_we && !d_bad;
                  m_be    = d_be;
                  m_addr  = {d_addr[31:2], 2'b00};
                  m_wdata = d_wrep;
               end
            end
         end
         WAIT: begin
            if (cnt == CNT_W'(1)) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt         <= '0;
         starve      <= '0;
         own_d       <= 1'b0;
         own_we      <= 1'b0;
         own_err     <= 1'b0;
         if_rvalid_q <= 1'b0;
         d_rvalid_q  <= 1'b0;
         d_err_q     <= 1'b0;
         if_rdata_q  <= 32'h0;
         d_rdata_q   <= 32'h0;
      end else begin
         if_rvalid_q <= 1'b0;
         d_rvalid_q  <= 1'b0;

         if (if_gnt || d_gnt) begin
            cnt     <= CNT_W'(MEM_LAT);
            own_d   <= d_gnt;
            own_we  <= d_we;
            own_err <= d_bad;
         end else if (state == WAIT) begin
            cnt <= cnt - CNT_W'(1);
         end

         if (last_cycle) begin
            if (own_d) begin
               d_rvalid_q <= 1'b1;
               d_err_q    <= own_err;
               if (!own_we && !own_err) d_rdata_q <= m_rdata;
            end else begin
               if_rvalid_q <= 1'b1;
               if_rdata_q  <= m_rdata;
            end
         end

         if (!if_req || if_gnt)
            starve <= '0;
         else if (d_gnt && (starve != STV_W'(STARVE_LIMIT)))
            starve <= starve + STV_W'(1);
      end
   end

   // Reset forces every output low, including a response that would land this cycle.
   assign if_rvalid = if_rvalid_q && !rst;
   assign d_rvalid  = d_rvalid_q && !rst;
   assign if_rdata  = rst ? 32'h0 : if_rdata_q;
   assign d_rdata   = rst ? 32'h0 : d_rdata_q;
   assign d_err     = d_err_q && !rst;
   assign busy      = !rst && ((state != IDLE) || if_gnt || d_gnt);

endmodule
